// File: rtl/bcd_counter2.sv
// bcd_counter2: two-digit BCD up/down counter with load, terminal pulse and load-error pulse.
// Latency: one cycle from sampled rst/load/en to updated q, tc and load_err (all registered).
// Backpressure: none; the counter takes a decision every cycle in the order rst > load > en.
module bcd_counter2 #(
  parameter int MOD = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] din,
  output logic [7:0] q,
  output logic       tc,
  output logic       load_err
);

  // Terminal count MOD-1 split into its decimal digits.
  localparam logic [3:0] MAX_TENS  = 4'((MOD - 1) / 10);
  localparam logic [3:0] MAX_UNITS = 4'((MOD - 1) % 10);
  localparam logic [7:0] MAX_BCD   = {MAX_TENS, MAX_UNITS};
  localparam logic [7:0] MOD_VAL   = 8'(MOD);

  logic [3:0] tens;
  logic [3:0] units;
  logic [7:0] din_dec;
  logic       din_ok;
  logic       at_max;
  logic       at_zero;
  logic [7:0] q_inc;
  logic [7:0] q_dec;
  logic [7:0] q_nxt;
  logic       tc_nxt;
  logic       err_nxt;

  assign tens  = q[7:4];
  assign units = q[3:0];

  // Binary value of the load word; worst case 15*10+15 = 165 still fits in 8 bits,
  // so illegal nibbles cannot alias into a small legal value.
  assign din_dec = ({4'd0, din[7:4]} * 8'd10) + {4'd0, din[3:0]};
  assign din_ok  = (din[7:4] <= 4'd9) && (din[3:0] <= 4'd9) && (din_dec < MOD_VAL);

  assign at_max  = (q == MAX_BCD);
  assign at_zero = (q == 8'h00);

  // Plain BCD step; terminal cases are handled separately below, so the tens
  // digit never steps outside 0..9 here.
  always_comb begin
    q_inc = {tens, units + 4'd1};
    if (units == 4'd9) begin
      q_inc = {tens + 4'd1, 4'd0};
    end
  end

  always_comb begin
    q_dec = {tens, units - 4'd1};
    if (units == 4'd0) begin
      q_dec = {tens - 4'd1, 4'd9};
    end
  end

  always_comb begin
    q_nxt   = q;
    tc_nxt  = 1'b0;
    err_nxt = 1'b0;
    if (load) begin
      // A load cycle never produces tc, even with en high.
      if (din_ok) begin
        q_nxt = din;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          tc_nxt = 1'b1;
`ifdef BCD_COUNTER2_SAT_EN
          q_nxt  = q;
`else
          q_nxt  = 8'h00;
`endif
        end else begin
          q_nxt = q_inc;
        end
      end else begin
        if (at_zero) begin
          tc_nxt = 1'b1;
`ifdef BCD_COUNTER2_SAT_EN
          q_nxt  = q;
`else
          q_nxt  = MAX_BCD;
`endif
        end else begin
          q_nxt = q_dec;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= 8'h00;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      q        <= q_nxt;
      tc       <= tc_nxt;
      load_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_counter2.sv
// tb_bcd_counter2: drives a MOD=100 and a MOD=60 counter with shared stimulus and
// checks both against a decimal-integer reference model every cycle.
// Directed literal checks pin the model; a long randomized run follows.
module tb_bcd_counter2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] qa, qb;
  logic       tca, tcb, erra, errb;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Reference state: plain decimal counts.
  int cnt_a = 0;
  int cnt_b = 0;
  bit etc_a = 1'b0, eerr_a = 1'b0;
  bit etc_b = 1'b0, eerr_b = 1'b0;

  always #5 clk = ~clk;

  bcd_counter2 #(.MOD(100)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(qa), .tc(tca), .load_err(erra)
  );

  bcd_counter2 #(.MOD(60)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(qb), .tc(tcb), .load_err(errb)
  );

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  // One clock of the behavioural rules for a counter of modulus mod.
  function automatic void mstep(input int mod, input int cur,
                                output int nxt, output bit tcx, output bit errx);
    int t;
    int u;
    nxt  = cur;
    tcx  = 1'b0;
    errx = 1'b0;
    if (rst === 1'b1) begin
      nxt = 0;
    end else if (load === 1'b1) begin
      t = int'(din[7:4]);
      u = int'(din[3:0]);
      if (t < 10 && u < 10 && (t * 10 + u) < mod) nxt = t * 10 + u;
      else errx = 1'b1;
    end else if (en === 1'b1) begin
      if (up) begin
        if (cur == mod - 1) begin
          tcx = 1'b1;
`ifdef BCD_COUNTER2_SAT_EN
          nxt = cur;
`else
          nxt = 0;
`endif
        end else begin
          nxt = cur + 1;
        end
      end else begin
        if (cur == 0) begin
          tcx = 1'b1;
`ifdef BCD_COUNTER2_SAT_EN
          nxt = cur;
`else
          nxt = mod - 1;
`endif
        end else begin
          nxt = cur - 1;
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    mstep(100, cnt_a, cnt_a, etc_a, eerr_a);
    mstep(60,  cnt_b, cnt_b, etc_b, eerr_b);
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_q_a",    qa,           to_bcd(cnt_a));
      check("model_tc_a",   {7'd0, tca},  {7'd0, etc_a});
      check("model_err_a",  {7'd0, erra}, {7'd0, eerr_a});
      check("model_q_b",    qb,           to_bcd(cnt_b));
      check("model_tc_b",   {7'd0, tcb},  {7'd0, etc_b});
      check("model_err_b",  {7'd0, errb}, {7'd0, eerr_b});
      check("nibble_ok_a",  {7'd0, (qa[7:4] <= 4'd9) && (qa[3:0] <= 4'd9)}, 8'd1);
      check("nibble_ok_b",  {7'd0, (qb[7:4] <= 4'd9) && (qb[3:0] <= 4'd9)}, 8'd1);
    end
  end

  // Apply one cycle of inputs (called just after a falling edge) and return
  // just after the next falling edge, when the result of that rising edge is visible.
  task automatic cyc(input bit r, input bit l, input bit e, input bit u, input logic [7:0] d);
    rst  = r;
    load = l;
    en   = e;
    up   = u;
    din  = d;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] rd;
    @(negedge clk);
    #1;

    // Reset wins over a simultaneous load.
    cyc(1, 1, 0, 0, 8'h45);
    cyc(1, 1, 0, 0, 8'h45);
    check("rst_q_a",   qa,           8'h00);
    check("rst_tc_a",  {7'd0, tca},  8'h00);
    check("rst_err_a", {7'd0, erra}, 8'h00);
    check("rst_q_b",   qb,           8'h00);
    check("rst_err_b", {7'd0, errb}, 8'h00);
    chk_en = 1'b1;

    // Decade carry.
    cyc(0, 1, 0, 0, 8'h09);
    check("load09_q_a", qa, 8'h09);
    cyc(0, 0, 1, 1, 8'h00);
    check("carry_q_a",  qa, 8'h10);
    check("carry_tc_a", {7'd0, tca}, 8'h00);

    // 99 is legal for MOD=100, out of range for MOD=60.
    cyc(0, 1, 0, 0, 8'h99);
    check("load99_q_a",   qa, 8'h99);
    check("load99_q_b",   qb, 8'h10);
    check("load99_err_b", {7'd0, errb}, 8'h01);
    check("load99_err_a", {7'd0, erra}, 8'h00);

    // Up wrap at 99.
    cyc(0, 0, 1, 1, 8'h00);
`ifdef BCD_COUNTER2_SAT_EN
    check("upwrap_q_a", qa, 8'h99);
`else
    check("upwrap_q_a", qa, 8'h00);
`endif
    check("upwrap_tc_a", {7'd0, tca}, 8'h01);
    check("upwrap_q_b",  qb, 8'h11);
    cyc(0, 0, 0, 0, 8'h00);
    check("tc_pulse_end_a", {7'd0, tca}, 8'h00);

    // Down wrap with MOD=60.
    cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
`ifdef BCD_COUNTER2_SAT_EN
    check("dnwrap_q_b", qb, 8'h00);
    check("dnwrap_q_a", qa, 8'h00);
`else
    check("dnwrap_q_b", qb, 8'h59);
    check("dnwrap_q_a", qa, 8'h99);
`endif
    check("dnwrap_tc_b", {7'd0, tcb}, 8'h01);

    // Invalid loads leave q alone and pulse load_err.
    cyc(0, 1, 0, 0, 8'h37);
    cyc(0, 1, 0, 0, 8'h3A);
    check("bad3A_q_a",   qa, 8'h37);
    check("bad3A_err_a", {7'd0, erra}, 8'h01);
    cyc(0, 1, 0, 0, 8'hA0);
    check("badA0_q_a",   qa, 8'h37);
    check("badA0_err_a", {7'd0, erra}, 8'h01);
    cyc(0, 1, 0, 0, 8'h75);
    check("load75_q_a",   qa, 8'h75);
    check("load75_err_a", {7'd0, erra}, 8'h00);
    check("bad75_q_b",    qb, 8'h37);
    check("bad75_err_b",  {7'd0, errb}, 8'h01);

    // Load with en at the terminal value: no tc.
    cyc(0, 1, 0, 0, 8'h99);
    cyc(0, 1, 1, 1, 8'h99);
    check("loaden_q_a",  qa, 8'h99);
    check("loaden_tc_a", {7'd0, tca}, 8'h00);

    // Three consecutive up steps from 99.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 8'h00);
`ifdef BCD_COUNTER2_SAT_EN
      check("sat_q_a",  qa, 8'h99);
      check("sat_tc_a", {7'd0, tca}, 8'h01);
`else
      check("post99_q_a",  qa, to_bcd(i));
      check("post99_tc_a", {7'd0, tca}, (i == 0) ? 8'h01 : 8'h00);
`endif
    end

    // Reset overrides a count, counting resumes on the next enabled edge.
    cyc(1, 1, 1, 1, 8'h55);
    check("rst_en_q_a", qa, 8'h00);
    check("rst_en_q_b", qb, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
`ifdef BCD_COUNTER2_SAT_EN
    check("resume_q_b", qb, 8'h00);
`else
    check("resume_q_b", qb, 8'h59);
`endif

    // Randomized run; the every-cycle comparator does the checking.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(1, 0) == 1) rd = {4'($urandom_range(9, 0)), 4'($urandom_range(9, 0))};
      else rd = 8'($urandom);
      cyc(($urandom_range(99, 0) < 2),
          ($urandom_range(99, 0) < 15),
          ($urandom_range(99, 0) < 70),
          ($urandom_range(1, 0) == 1),
          rd);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_counter2.md
BCD_COUNTER2 -- requirements
Module: bcd_counter2

Interface
REQ-001 Parameter MOD, default 100, is the count modulus: the legal range is 2..100, and the terminal count is MOD-1, expressed in BCD.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 en  input  1  count enable; one step per cycle while high.
REQ-005 up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
REQ-006 load  input  1  load strobe; has priority over en.
REQ-007 din  input  8  load value: din[7:4] is the tens BCD digit, din[3:0] is the units BCD digit.
REQ-008 q  output  8  current count: q[7:4] is tens, q[3:0] is units; each digit is always in 0..9.
REQ-009 tc  output  1  terminal pulse, high for one cycle.
REQ-010 load_err  output  1  one-cycle pulse flagging a rejected load.

Function
REQ-011 The registered count q SHALL only ever hold values 0..MOD-1, and each nibble SHALL always be 0..9.
REQ-012 Priority per cycle SHALL be rst > load > en; when none of them is active, q holds its value.
REQ-013 Load with valid data: when load=1, both din nibbles are ≤9 and the decimal value of din is below MOD, q SHALL equal din one cycle later; load_err=0.
REQ-014 Load with invalid data: when load=1 and any din nibble is ≥10 (codes 1010..1111) or the value is ≥MOD, q SHALL hold its value and load_err SHALL pulse high for exactly that following cycle.
REQ-015 Increment: units rolls from 9 to 0 with carry into tens; tens increments only on that carry.
REQ-016 Decrement: units rolls from 0 to 9 with borrow from tens; tens decrements only on that borrow.
REQ-017 Up wrap: with en=1, up=1 and q=MOD-1, q SHALL become 00 and tc SHALL be high for the next cycle.
REQ-018 Down wrap: with en=1, up=0 and q=00, q SHALL become MOD-1 and tc SHALL be high for the next cycle.
REQ-019 tc and load_err SHALL be registered outputs and SHALL be 0 in every cycle not named in REQ-014, REQ-017 or REQ-018.
REQ-020 A cycle with load=1 SHALL never assert tc, even when en=1 in the same cycle.
REQ-021 Count latency SHALL be one cycle from the en edge-sample to the updated q; there SHALL be no combinational path from any input to any output.
REQ-022 Toggling up between cycles SHALL take effect on the very next step, with no dead cycle.

Reset
REQ-023 While rst=1 at a rising edge, q SHALL become 8'h00, tc SHALL become 0 and load_err SHALL become 0.
REQ-024 rst asserted in the same cycle as load or en SHALL override both; the load or count is discarded.
REQ-025 After reset is released, counting SHALL resume on the first edge with en=1.

Configuration
REQ-026 Macro BCD_COUNTER2_SAT_EN selects between wrap and saturate behaviour.
REQ-027 When BCD_COUNTER2_SAT_EN is defined, up-count at MOD-1 and down-count at 00 SHALL hold q; tc still pulses on each such attempted step.
REQ-028 When BCD_COUNTER2_SAT_EN is not defined, wrap behaviour per REQ-017 and REQ-018 applies.

Verification
REQ-029 Reset sequence: rst=1 for 2 cycles with load=1 and din=8'h45 -> q=8'h00, tc=0, load_err=0.
REQ-030 Decade carry: load 8'h09, then en=1, up=1 for 1 cycle -> q=8'h10, tc=0.
REQ-031 Up wrap (MOD=100, macro undefined): load 8'h99, then en=1, up=1 -> q=8'h00, tc pulses high for 1 cycle.
REQ-032 Down wrap with MOD=60: load 8'h00, then en=1, up=0 -> q=8'h59, tc pulses high for 1 cycle.
REQ-033 Invalid load: q=8'h37, then load=1 with din=8'h3A, and separately din=8'hA0 -> q stays 8'h37, load_err pulses each time; MOD=60 with din=8'h75 -> rejected the same way.
REQ-034 Saturation (BCD_COUNTER2_SAT_EN defined): q=8'h99, en=1, up=1 for 3 cycles -> q stays 8'h99, tc high for each of those 3 cycles; every cycle, assert each q nibble ≤9.
